// File: rtl/dprambe_arb.sv
`default_nettype none
// ============================================================================
//  Module   : dprambe_arb
//  Purpose  : Two-requester round-robin arbiter sharing one port of a
//             byte-enable dual-port RAM. Issues at most one access per
//             clock and returns read data one cycle after acceptance.
//             A burst limit bounds how long one requester may hold the
//             port while the other is waiting.
//  Ports    : clk, rst_n              - clock, async active-low reset
//             reqN_valid/ready        - request handshake (N = 0,1)
//             reqN_we/addr/wdata/be   - request payload
//             rspN_valid, rsp_rdata   - read response (shared data bus)
//             gnt                     - one-hot accepted requester
//             ram_we/addr/data/be     - RAM port drive
//             ram_q                   - RAM read data
//  Revision : 1.0 - initial release
// ============================================================================
module dprambe_arb #(
  parameter int DWIDTH   = 16,
  parameter int AWIDTH   = 16,
  parameter int BEWIDTH  = DWIDTH / 8,
  parameter     REGOUT   = "Y",
  parameter int MAXBURST = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic               req0_we,
  input  logic [AWIDTH-1:0]  req0_addr,
  input  logic [DWIDTH-1:0]  req0_wdata,
  input  logic [BEWIDTH-1:0] req0_be,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic               req1_we,
  input  logic [AWIDTH-1:0]  req1_addr,
  input  logic [DWIDTH-1:0]  req1_wdata,
  input  logic [BEWIDTH-1:0] req1_be,
  output logic               rsp0_valid,
  output logic               rsp1_valid,
  output logic [DWIDTH-1:0]  rsp_rdata,
  output logic [1:0]         gnt,
  output logic               ram_we,
  output logic [AWIDTH-1:0]  ram_addr,
  output logic [DWIDTH-1:0]  ram_data,
  output logic [BEWIDTH-1:0] ram_be,
  input  logic [DWIDTH-1:0]  ram_q
);

  localparam int                 c_cnt_w = $clog2(MAXBURST + 1);
  localparam logic [c_cnt_w-1:0] c_max   = c_cnt_w'(MAXBURST);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

  logic               r_own;       // last owner: 0 = req0, 1 = req1
  logic [c_cnt_w-1:0] r_cnt;       // consecutive grants to r_own, saturating
  logic [1:0]         r_rd_pend;   // one-hot: read response due this cycle
  logic [1:0]         w_gnt;
  logic [DWIDTH-1:0]  w_rdata;

  // Grant decision. Forced idle while reset is held so that nothing reaches
  // the RAM and no handshake completes during reset.
  always_comb begin
    w_gnt = 2'b00;
    if (rst_n) begin
      if (req0_valid && req1_valid) begin
        // Owner keeps the port until its burst budget is used up.
        if (r_cnt < c_max) w_gnt = r_own ? 2'b10 : 2'b01;
        else               w_gnt = r_own ? 2'b01 : 2'b10;
      end else if (req0_valid) begin
        w_gnt = 2'b01;
      end else if (req1_valid) begin
        w_gnt = 2'b10;
      end
    end
  end

  assign gnt        = w_gnt;
  assign req0_ready = w_gnt[0];
  assign req1_ready = w_gnt[1];

  // RAM drive: zero when idle so the port is quiet between accesses.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_data = '0;
    ram_be   = '0;
    if (w_gnt[0]) begin
      ram_we   = req0_we;
      ram_addr = req0_addr;
      ram_data = req0_wdata;
      ram_be   = req0_be;
    end else if (w_gnt[1]) begin
      ram_we   = req1_we;
      ram_addr = req1_addr;
      ram_data = req1_wdata;
      ram_be   = req1_be;
    end
  end

  // Ownership / burst counter. The reset state (owner 1, counter saturated)
  // makes the first tie after reset go to req0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_own <= 1'b1;
      r_cnt <= c_max;
    end else if (|w_gnt) begin
      if (w_gnt[1] == r_own) begin
        if (r_cnt != c_max) r_cnt <= r_cnt + c_one;
      end else begin
        r_own <= w_gnt[1];
        r_cnt <= c_one;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_pend <= 2'b00;
    else        r_rd_pend <= {w_gnt[1] & ~req1_we, w_gnt[0] & ~req0_we};
  end

  generate
    if (REGOUT == "N") begin : g_regout_n
      // RAM output is unregistered: capture it so data lines up with the
      // one-cycle response slot.
      logic [DWIDTH-1:0] r_qreg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_qreg <= '0;
        else        r_qreg <= ram_q;
      end
      assign w_rdata = r_qreg;
    end else begin : g_regout_y
      assign w_rdata = ram_q;
    end
  endgenerate

  assign rsp0_valid = r_rd_pend[0];
  assign rsp1_valid = r_rd_pend[1];
  assign rsp_rdata  = (|r_rd_pend) ? w_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_dprambe_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dprambe_arb
//  Purpose  : Self-checking bench for dprambe_arb with a behavioural
//             registered-output byte-enable RAM on the shared port.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dprambe_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic        req0_we, req1_we;
  logic [15:0] req0_addr, req1_addr, req0_wdata, req1_wdata;
  logic [1:0]  req0_be, req1_be;
  logic        rsp0_valid, rsp1_valid;
  logic [15:0] rsp_rdata;
  logic [1:0]  gnt;
  logic        ram_we;
  logic [15:0] ram_addr, ram_data, ram_q;
  logic [1:0]  ram_be;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dprambe_arb #(
    .DWIDTH(16), .AWIDTH(16), .BEWIDTH(2), .REGOUT("Y"), .MAXBURST(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_be(req0_be),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_be(req1_be),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_rdata(rsp_rdata),
    .gnt(gnt), .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_be(ram_be), .ram_q(ram_q)
  );

  // Behavioural RAM, registered output.
  logic [15:0] mem [0:255];
  initial for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  always @(posedge clk) begin
    if (ram_we) begin
      if (ram_be[0]) mem[ram_addr[7:0]][7:0]  <= ram_data[7:0];
      if (ram_be[1]) mem[ram_addr[7:0]][15:8] <= ram_data[15:8];
    end
    ram_q <= mem[ram_addr[7:0]];
  end

  typedef struct {
    logic        v0, we0; logic [15:0] a0, d0; logic [1:0] be0;
    logic        v1, we1; logic [15:0] a1, d1; logic [1:0] be1;
    logic [1:0]  e_gnt; logic e_we, e_r0, e_r1; logic [15:0] e_rd;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic v0, we0, input logic [15:0] a0, d0, input logic [1:0] be0,
                     input logic v1, we1, input logic [15:0] a1, d1, input logic [1:0] be1,
                     input logic [1:0] eg, input logic ewe, er0, er1, input logic [15:0] erd);
    vec_t v;
    v.v0 = v0; v.we0 = we0; v.a0 = a0; v.d0 = d0; v.be0 = be0;
    v.v1 = v1; v.we1 = we1; v.a1 = a1; v.d1 = d1; v.be1 = be1;
    v.e_gnt = eg; v.e_we = ewe; v.e_r0 = er0; v.e_r1 = er1; v.e_rd = erd;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, we0, input logic [15:0] a0, d0, input logic [1:0] be0,
                       input logic v1, we1, input logic [15:0] a1, d1, input logic [1:0] be1);
    req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0; req0_be = be0;
    req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1; req1_be = be1;
  endtask

  task automatic idle();
    drive(0, 0, 16'h0, 16'h0, 2'b00, 0, 0, 16'h0, 16'h0, 2'b00);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compares one cycle's outputs; read data only when a response is due.
  task automatic check_cyc(input string tag, input logic [1:0] eg, input logic ewe,
                           input logic er0, er1, input logic [15:0] erd);
    chk({tag, ".gnt"},   {30'd0, gnt}, {30'd0, eg});
    chk({tag, ".ready"}, {30'd0, req1_ready, req0_ready}, {30'd0, eg});
    chk({tag, ".ramwe"}, {31'd0, ram_we}, {31'd0, ewe});
    chk({tag, ".rsp"},   {30'd0, rsp1_valid, rsp0_valid}, {30'd0, er1, er0});
    if (er0 || er1) chk({tag, ".rdata"}, {16'd0, rsp_rdata}, {16'd0, erd});
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, ".gnt"},   {30'd0, gnt}, 32'd0);
    chk({tag, ".ready"}, {30'd0, req1_ready, req0_ready}, 32'd0);
    chk({tag, ".rsp"},   {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk({tag, ".rdata"}, {16'd0, rsp_rdata}, 32'd0);
    chk({tag, ".ram"},   {ram_we, ram_be, ram_addr, 13'd0}, 32'd0);
    chk({tag, ".ramd"},  {16'd0, ram_data}, 32'd0);
  endtask

  initial begin
    logic [1:0] g, g_prev;

    // ---- Reset defaults: both requesting writes, reset held ----
    rst_n = 1'b0;
    drive(1, 1, 16'h0010, 16'h1111, 2'b11, 1, 1, 16'h0020, 16'h2222, 2'b11);
    @(negedge clk);
    check_quiet("reset");
    step();
    step();

    // ---- Table: write/read, byte enables, tie handling ----
    //   v0 we0 a0        d0        be0    v1 we1 a1        d1        be1    gnt   we r0 r1 rdata
    add(1, 1, 16'h0010, 16'hBEEF, 2'b11, 0, 0, 16'h0000, 16'h0000, 2'b00, 2'b01, 1, 0, 0, 16'h0000);
    add(1, 0, 16'h0010, 16'h0000, 2'b00, 0, 0, 16'h0000, 16'h0000, 2'b00, 2'b01, 0, 0, 0, 16'h0000);
    add(0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0, 16'h0000, 16'h0000, 2'b00, 2'b00, 0, 1, 0, 16'hBEEF);
    add(0, 0, 16'h0000, 16'h0000, 2'b00, 1, 1, 16'h0020, 16'h1234, 2'b11, 2'b10, 1, 0, 0, 16'h0000);
    add(0, 0, 16'h0000, 16'h0000, 2'b00, 1, 1, 16'h0020, 16'hAB00, 2'b10, 2'b10, 1, 0, 0, 16'h0000);
    add(0, 0, 16'h0000, 16'h0000, 2'b00, 1, 0, 16'h0020, 16'h0000, 2'b00, 2'b10, 0, 0, 0, 16'h0000);
    add(0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0, 16'h0000, 16'h0000, 2'b00, 2'b00, 0, 0, 1, 16'hAB34);
    add(1, 0, 16'h0010, 16'h0000, 2'b00, 1, 0, 16'h0020, 16'h0000, 2'b00, 2'b10, 0, 0, 0, 16'h0000);
    add(1, 0, 16'h0010, 16'h0000, 2'b00, 1, 0, 16'h0020, 16'h0000, 2'b00, 2'b01, 0, 0, 1, 16'hAB34);
    add(0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0, 16'h0000, 16'h0000, 2'b00, 2'b00, 0, 1, 0, 16'hBEEF);

    rst_n = 1'b1;
    foreach (tbl[i]) begin
      drive(tbl[i].v0, tbl[i].we0, tbl[i].a0, tbl[i].d0, tbl[i].be0,
            tbl[i].v1, tbl[i].we1, tbl[i].a1, tbl[i].d1, tbl[i].be1);
      @(negedge clk);
      check_cyc($sformatf("vec%0d", i), tbl[i].e_gnt, tbl[i].e_we,
                tbl[i].e_r0, tbl[i].e_r1, tbl[i].e_rd);
      step();
    end
    idle();
    @(negedge clk);
    check_quiet("idle");
    step();

    // ---- Contention from reset: 01 x4, 10 x4, 01 x4 ----
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive(1, 0, 16'h0010, 16'h0000, 2'b00, 1, 0, 16'h0020, 16'h0000, 2'b00);
    g_prev = 2'b00;
    for (int k = 0; k < 12; k++) begin
      g = ((k / 4) % 2 == 1) ? 2'b10 : 2'b01;
      @(negedge clk);
      check_cyc($sformatf("cont%0d", k), g, 1'b0, g_prev[0], g_prev[1],
                g_prev[0] ? 16'hBEEF : 16'hAB34);
      g_prev = g;
      step();
    end
    idle();
    @(negedge clk);
    check_cyc("cont_drain", 2'b00, 1'b0, 1'b1, 1'b0, 16'hBEEF);
    step();

    // ---- Single requester: req1 alone never stalls; req0 then wins ----
    drive(0, 0, 16'h0000, 16'h0000, 2'b00, 1, 0, 16'h0020, 16'h0000, 2'b00);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_cyc($sformatf("single%0d", k), 2'b10, 1'b0, 1'b0, k > 0, 16'hAB34);
      step();
    end
    drive(1, 0, 16'h0010, 16'h0000, 2'b00, 1, 0, 16'h0020, 16'h0000, 2'b00);
    @(negedge clk);
    check_cyc("single_join", 2'b01, 1'b0, 1'b0, 1'b1, 16'hAB34);
    step();
    idle();
    @(negedge clk);
    check_cyc("single_drain", 2'b00, 1'b0, 1'b1, 1'b0, 16'hBEEF);
    step();

    // ---- Mid-operation reset: pending response dropped, no writes ----
    drive(1, 0, 16'h0010, 16'h0000, 2'b00, 0, 0, 16'h0000, 16'h0000, 2'b00);
    @(negedge clk);
    check_cyc("mid_rd", 2'b01, 1'b0, 1'b0, 1'b0, 16'h0000);
    step();
    rst_n = 1'b0;
    drive(1, 1, 16'h0010, 16'h5555, 2'b11, 1, 1, 16'h0020, 16'h6666, 2'b11);
    #1;
    check_quiet("mid_rst");
    step();
    check_quiet("mid_rst_hold");
    step();
    rst_n = 1'b1;
    drive(1, 0, 16'h0010, 16'h0000, 2'b00, 1, 0, 16'h0020, 16'h0000, 2'b00);
    @(negedge clk);
    check_cyc("post_rst_tie", 2'b01, 1'b0, 1'b0, 1'b0, 16'h0000);
    step();
    @(negedge clk);
    check_cyc("post_rst_rd", 2'b01, 1'b0, 1'b1, 1'b0, 16'hBEEF);
    step();
    idle();
    @(negedge clk);
    check_cyc("post_rst_rd2", 2'b00, 1'b0, 1'b1, 1'b0, 16'hBEEF);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dprambe_arb.md
# dprambe_arb

Two-requester round-robin arbiter that shares one port of a `dprambe` byte-enable dual-port RAM. It accepts read/write requests from two independent masters over valid/ready handshakes and issues at most one access per clock to the RAM port. It routes read data back with a fixed one-cycle response latency. A configurable burst limit bounds how long one requester may hold the port while the other waits. One instance sits in front of each RAM port that needs sharing.

## Interface

Parameters:

- `DWIDTH`, 16, data width; must match the RAM, multiple of 8.
- `AWIDTH`, 16, address width; must match the RAM.
- `BEWIDTH`, `DWIDTH/8`, byte-enable width.
- `REGOUT`, "Y", must match the RAM's `REGOUT`. "Y" means `ram_q` is already registered; "N" means the arbiter registers `ram_q` internally.
- `MAXBURST`, 4, maximum consecutive accepted transfers for one requester while the other is requesting; ≥1.

Ports:

- `clk`  in  1  single clock for all logic; the RAM port clock connects to the same net.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req0_valid`, `req1_valid`  in  1  request present.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle.
- `req0_we`, `req1_we`  in  1  1 = write, 0 = read.
- `req0_addr`, `req1_addr`  in  AWIDTH  word address.
- `req0_wdata`, `req1_wdata`  in  DWIDTH  write data.
- `req0_be`, `req1_be`  in  BEWIDTH  byte enables; used for writes only.
- `rsp0_valid`, `rsp1_valid`  out  1  read data for that requester is on `rsp_rdata`.
- `rsp_rdata`  out  DWIDTH  shared read-data bus.
- `gnt`  out  2  one-hot: the requester accepted this cycle; 0 when idle.
- `ram_we`  out  1  to RAM `we`.
- `ram_addr`  out  AWIDTH  to RAM `addr`.
- `ram_data`  out  DWIDTH  to RAM `data`.
- `ram_be`  out  BEWIDTH  to RAM `be`.
- `ram_q`  in  DWIDTH  from RAM `q`.

## Operation

**State registers:**

- `own`: last owner, 1 bit.
- `cnt`: consecutive-grant counter, saturates at MAXBURST.
- `rd_pend`: 2-bit one-hot read-response pipeline.
- When `REGOUT`="N" only: data register `qreg`.

**Grant decision** (combinational, from the valids, `own` and `cnt`):

- Neither valid: no grant.
- Exactly one valid: grant that requester, regardless of `cnt`.
- Both valid, `cnt` < MAXBURST: grant `own`.
- Both valid, `cnt` == MAXBURST: grant `!own`.

**Handshake and RAM drive:**

- `reqN_ready` = grant to N. Ready depends combinationally on valid; requesters must not make valid depend on ready.
- A transfer occurs when valid && ready. Requesters hold `addr`, `we`, `wdata` and `be` stable while valid and not ready.
- On a transfer, the RAM port is driven from the granted requester: `ram_we` = its `we`.
- When idle, `ram_we`=0 and `ram_addr`, `ram_data` and `ram_be` are driven to 0.

**Counter update** (on each transfer):

- If granted == `own`: `cnt` <= min(`cnt`+1, MAXBURST).
- Otherwise: `own` <= granted and `cnt` <= 1.
- Idle cycles leave `own` and `cnt` unchanged.

**Read responses:**

- An accepted read sets `rd_pend[N]` for the next cycle.
- In that cycle `rspN_valid`=1 and `rsp_rdata` = read data: `ram_q` when `REGOUT`="Y", `qreg` when "N".
- There is no response backpressure. At most one response is asserted per cycle.
- Writes produce no response.

**Ordering:**

- Accesses reach the RAM in acceptance order.
- A write accepted at cycle t is visible to a read accepted at t+1 or later.
- A write to a byte lane with `be`=0 leaves that lane unchanged.

## Timing

- Reset (asynchronous assert, synchronous-clean release): `own`=1, `cnt`=MAXBURST, `rd_pend`=0, `qreg`=0.
- Outputs during and after reset: all `ready`, `rsp*_valid` and `gnt` = 0; `rsp_rdata`=0; all `ram_*` = 0.
- The first tie after reset goes to req0.
- Request-to-RAM latency: 0 cycles; `ram_*` changes in the same cycle as ready.
- Read response: exactly 1 cycle after acceptance.
- Throughput: one transfer per cycle. Back-to-back reads from alternating requesters produce alternating responses on consecutive cycles.
- Reset asserted mid-operation: in-flight responses are dropped and `rsp*_valid` goes low immediately; no RAM write occurs while `rst_n`=0.
- Both requesters continuously valid: the grant pattern is MAXBURST cycles to one requester, then MAXBURST to the other, repeating.
- MAXBURST=1: strict alternation under contention.

## Test plan

- **Reset defaults:** assert `rst_n`=0 with both valids high → all outputs 0, no `ram_we`. Release, with both requesting reads → `gnt`=01 first.
- **Write then read:** req0 writes 0xBEEF to addr 0x0010 with `be`=11, then reads 0x0010 next cycle → `rsp0_valid` one cycle after the read, `rsp_rdata`=0xBEEF.
- **Byte enables:** req1 writes 0x1234 to 0x0020, then writes 0xAB00 with `be`=10, then reads → `rsp1_valid` with 0xAB34.
- **Contention:** MAXBURST=4, both requesters issue continuous reads → `gnt` sequence 01×4, 10×4, 01×4. Each response tagged to the correct requester 1 cycle later.
- **Single requester:** only req1 valid for 10 cycles → ready every cycle. `cnt` saturates at 4 with no stall. When req0 then asserts, it is granted on the next cycle.
- **Mid-operation reset:** read accepted, `rst_n` low in the following cycle before the clock edge → `rsp*_valid`=0. After release, `own`=1, `cnt`=MAXBURST, and a tie goes to req0.
